// File: rtl/conv_window_reader.sv
// conv_window_reader: raster-scans an IMG_W x IMG_H image held in SRAM and presents each 3x3 window.
// Define WIN_REPLICATE_EN to clamp out-of-image taps to the border instead of zero padding.
module conv_window_reader #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 128,
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      sram_en,
  output logic                      sram_wen,
  output logic [ADDR_W-1:0]         sram_addr,
  output logic [DATA_W-1:0]         sram_d,
  input  logic [DATA_W-1:0]         sram_q,
  output logic                      win_valid,
  input  logic                      win_ready,
  output logic [9*DATA_W-1:0]       win_data,
  output logic [$clog2(IMG_W)-1:0]  win_x,
  output logic [$clog2(IMG_H)-1:0]  win_y
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  typedef enum logic [1:0] {IDLE, FETCH, OUT, DONE} state_t;
  state_t state, state_nxt;

  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [3:0]        tap;
  logic [3:0]        cap_k;
  logic [8:0]        pad;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] tap_addr;
  logic [DATA_W-1:0] taps [9];
  logic              tap_in;
  logic              issue;
  logic              last;
  int                dx, dy, col, row;

  // Tap k sits at (x + k%3 - 1, y + k/3 - 1)
  always_comb begin
    dx  = int'(tap) % 3 - 1;
    dy  = int'(tap) / 3 - 1;
    col = int'(x) + dx;
    row = int'(y) + dy;
`ifdef WIN_REPLICATE_EN
    if (col < 0) col = 0;
    else if (col > IMG_W - 1) col = IMG_W - 1;
    if (row < 0) row = 0;
    else if (row > IMG_H - 1) row = IMG_H - 1;
    tap_in = 1'b1;
`else
    tap_in = (col >= 0) && (col < IMG_W) && (row >= 0) && (row < IMG_H);
`endif
    tap_addr = ADDR_W'(row * IMG_W + col);
  end

  always_comb begin
    issue     = (state == FETCH) && (tap < 4'd9);
    cap_k     = tap - 4'd1;
    last      = (x == XW'(IMG_W - 1)) && (y == YW'(IMG_H - 1));
    busy      = (state != IDLE);
    done      = (state == DONE);
    win_valid = (state == OUT);
    sram_en   = issue && tap_in;
    // Padded taps leave the bus parked on the last address actually issued
    sram_addr = sram_en ? tap_addr : addr_q;
    sram_wen  = 1'b1;
    sram_d    = '0;
    win_x     = x;
    win_y     = y;
    win_data  = '0;
    for (int unsigned k = 0; k < 9; k++) begin
      win_data[DATA_W*k +: DATA_W] = taps[k];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   if (tap == 4'd9) state_nxt = OUT;
      OUT:     if (win_ready) state_nxt = last ? DONE : FETCH;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x      <= '0;
      y      <= '0;
      tap    <= '0;
      pad    <= '0;
      addr_q <= '0;
      for (int unsigned k = 0; k < 9; k++) taps[k] <= '0;
    end else begin
      if (sram_en) addr_q <= tap_addr;
      case (state)
        IDLE: begin
          if (start) begin
            x   <= '0;
            y   <= '0;
            tap <= '0;
          end
        end
        FETCH: begin
          if (issue) pad[tap] <= !tap_in;
          // Read data lags the issue by one cycle, so capture trails the tap counter
          if (tap != 4'd0) taps[cap_k] <= pad[cap_k] ? '0 : sram_q;
          tap <= (tap == 4'd9) ? 4'd0 : tap + 4'd1;
        end
        OUT: begin
          if (win_ready && !last) begin
            if (x == XW'(IMG_W - 1)) begin
              x <= '0;
              y <= y + 1'b1;
            end else begin
              x <= x + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_window_reader.sv
// Self-checking bench for conv_window_reader on a 4x4 image with a behavioural SRAM and window model.
module tb_conv_window_reader;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done, sram_en, sram_wen;
  logic [3:0]  sram_addr;
  logic [7:0]  sram_d, sram_q;
  logic        win_valid, win_ready;
  logic [71:0] win_data;
  logic [1:0]  win_x, win_y;

  int n_tests = 0;
  int n_fail  = 0;
  bit ident;
  logic [7:0] mem [16];

  conv_window_reader #(.IMG_W(4), .IMG_H(4), .ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_d(sram_d),
    .sram_q(sram_q), .win_valid(win_valid), .win_ready(win_ready),
    .win_data(win_data), .win_x(win_x), .win_y(win_y)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (sram_en) sram_q <= mem[sram_addr];

`ifdef WIN_REPLICATE_EN
  int s00 [9] = '{0, 0, 1, 0, 0, 1, 4, 4, 5};
  int s33 [9] = '{10, 11, 11, 14, 15, 15, 14, 15, 15};
`else
  int s00 [9] = '{0, 0, 0, 0, 0, 1, 0, 4, 5};
  int s33 [9] = '{10, 11, 0, 14, 15, 0, 0, 0, 0};
`endif
  int s11 [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] want);
    n_tests++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  function automatic logic [71:0] pack9(input int t [9]);
    logic [71:0] r = '0;
    for (int k = 0; k < 9; k++) r[8*k +: 8] = 8'(t[k]);
    return r;
  endfunction

  function automatic logic [71:0] model_win(input int cx, input int cy);
    logic [71:0] r = '0;
    for (int k = 0; k < 9; k++) begin
      int c = cx + k % 3 - 1;
      int w = cy + k / 3 - 1;
`ifdef WIN_REPLICATE_EN
      c = (c < 0) ? 0 : (c > 3) ? 3 : c;
      w = (w < 0) ? 0 : (w > 3) ? 3 : w;
      r[8*k +: 8] = mem[w*4 + c];
`else
      r[8*k +: 8] = (c >= 0 && c < 4 && w >= 0 && w < 4) ? mem[w*4 + c] : 8'd0;
`endif
    end
    return r;
  endfunction

  function automatic int exp_reads(input int cx, input int cy);
    int n = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++) begin
`ifdef WIN_REPLICATE_EN
        n++;
`else
        if (cx+dx >= 0 && cx+dx < 4 && cy+dy >= 0 && cy+dy < 4) n++;
`endif
      end
    return n;
  endfunction

  task automatic run_frame(input string nm, input int sx, input int sy, input int slen,
                           input bit rnd, input int mid_cyc, input bit chk_time);
    int cyc = 0, hs = 0, ex = 0, ey = 0, reads = 0, stall = 0;
    int bad = 0, dcnt = 0, last_hs = -1, wen_bad = 0;
    bit seen = 0;
    logic [71:0] held = '0;
    @(negedge clk); start = 1'b1; win_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    while (cyc < 3000 && !(hs == 16 && cyc > last_hs + 3)) begin
      start = (cyc == mid_cyc);
      if (sram_en) reads++;
      if (done) dcnt++;
      if (sram_wen !== 1'b1 || sram_d !== 8'd0) wen_bad++;
      win_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (win_valid) begin
        if (!seen) begin
          seen = 1;
          held = win_data;
          chk($sformatf("%s_x%0d", nm, hs), 72'(win_x), 72'(ex));
          chk($sformatf("%s_y%0d", nm, hs), 72'(win_y), 72'(ey));
          chk($sformatf("%s_win(%0d,%0d)", nm, ex, ey), win_data, model_win(ex, ey));
          chk($sformatf("%s_reads(%0d,%0d)", nm, ex, ey), 72'(reads), 72'(exp_reads(ex, ey)));
          if (ident && ex == 0 && ey == 0) chk("spec_w00", win_data, pack9(s00));
          if (ident && ex == 1 && ey == 1) chk("spec_w11", win_data, pack9(s11));
          if (ident && ex == 3 && ey == 3) chk("spec_w33", win_data, pack9(s33));
          if (ex == sx && ey == sy) stall = slen;
        end
        if (stall > 0) begin
          win_ready = 1'b0;
          stall--;
        end
        if (win_data !== held || sram_en) bad++;
        if (win_ready) begin
          hs++;
          last_hs = cyc + 1;
          seen = 0;
          reads = 0;
          ex++;
          if (ex == 4) begin ex = 0; ey++; end
        end
      end else if (seen) begin
        bad++;
      end
      @(negedge clk); cyc++;
    end
    start = 1'b0;
    chk({nm, "_handshakes"}, 72'(hs), 72'd16);
    chk({nm, "_done_pulses"}, 72'(dcnt), 72'd1);
    chk({nm, "_out_stable"}, 72'(bad), 72'd0);
    chk({nm, "_no_write"}, 72'(wen_bad), 72'd0);
    chk({nm, "_idle_after"}, 72'(busy), 72'd0);
    if (chk_time) chk({nm, "_cycles"}, 72'(last_hs), 72'd176);
  endtask

  initial begin
    bit reached = 0;
    int dseen = 0;
    rst = 1'b1; start = 1'b0; win_ready = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    ident = 1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 72'(busy), 72'd0);
    chk("rst_done", 72'(done), 72'd0);
    chk("rst_en", 72'(sram_en), 72'd0);
    chk("rst_wen", 72'(sram_wen), 72'd1);
    chk("rst_valid", 72'(win_valid), 72'd0);
    chk("rst_addr", 72'(sram_addr), 72'd0);
    chk("rst_data", win_data, 72'd0);
    chk("rst_xy", 72'({win_x, win_y}), 72'd0);
    rst = 1'b0;

    // Abort a scan while fetching window (1,0)
    @(negedge clk); start = 1'b1; win_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 60 && !reached; i++) begin
      @(negedge clk);
      if (done) dseen++;
      if (busy && !win_valid && win_x == 2'd1) reached = 1;
    end
    chk("abort_reached", 72'(reached), 72'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", 72'(busy), 72'd0);
    chk("abort_en", 72'(sram_en), 72'd0);
    chk("abort_valid", 72'(win_valid), 72'd0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || busy) dseen++;
    end
    chk("abort_quiet", 72'(dseen), 72'd0);

    run_frame("A", -1, -1, 0, 0, 40, 1);
    run_frame("B", 2, 1, 20, 0, -1, 0);

    ident = 0;
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom_range(0, 255));
    run_frame("C", -1, -1, 0, 1, 25, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/conv_window_reader.md
Name: conv_window_reader

Overview:
- Read-side initiator for the single-port image SRAM (en, active-low wen, registered read address, one-cycle read latency).
- On a start pulse, raster-scans every pixel position of an IMG_W x IMG_H 8-bit gray image.
- For each position, fetches its 3x3 neighbourhood and presents the window to the convolution datapath over a valid/ready handshake.
- Never writes the SRAM.

Parameters:
- IMG_W, 256, image width in pixels; power of 2, at least 2.
- IMG_H, 128, image height in pixels; at least 2.
- ADDR_W, 15, SRAM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.
- DATA_W, 8, pixel width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a frame scan; honoured only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the frame completes.
- sram_en  out  1  SRAM enable.
- sram_wen  out  1  SRAM write enable, active low; constant 1.
- sram_addr  out  ADDR_W  SRAM address.
- sram_d  out  DATA_W  SRAM write data; constant 0.
- sram_q  in  DATA_W  SRAM read data; valid the cycle after the address is issued with sram_en=1.
- win_valid  out  1  window valid.
- win_ready  in  1  consumer ready.
- win_data  out  9*DATA_W  window; tap k occupies bits [DATA_W*k+DATA_W-1 : DATA_W*k].
- win_x  out  clog2(IMG_W)  centre column of the presented window.
- win_y  out  clog2(IMG_H)  centre row of the presented window.

Behaviour:
- Reset values: state=IDLE; busy, done, sram_en, win_valid = 0; sram_addr, win_data, win_x, win_y = 0; internal x, y, tap counter = 0. sram_wen = 1 at all times, including during reset.
- Reset asserted mid-frame aborts immediately. No done pulse. Resumption requires a new start.
- Taps are row-major, k = 0..8: dy = k/3 - 1, dx = k%3 - 1. Tap (dx,dy) refers to pixel (x+dx, y+dy). Address = row*IMG_W + col.
- FSM states: IDLE, FETCH, OUT, DONE.
- IDLE -> FETCH on start. Clears x and y to 0.
- FETCH takes exactly 10 cycles:
  - Cycles 0..8 issue tap k = cycle index.
  - In-range tap: sram_en=1, sram_addr driven to its address.
  - Out-of-range tap: sram_en=0, sram_addr holds its previous value, and a pad flag is recorded for that tap.
  - Cycles 1..9 capture tap k-1: sram_q if it was in range, else 0.
  - After cycle 9, go to OUT.
- OUT: win_valid=1. win_data, win_x and win_y stay stable until the handshake.
  - Handshake occurs when win_valid && win_ready on a rising edge.
  - Not the last pixel: advance x, wrapping to 0 and incrementing y at x = IMG_W-1, then go to FETCH.
  - At (IMG_W-1, IMG_H-1): go to DONE.
  - win_valid deasserts the cycle after the handshake.
- DONE: done=1 for exactly one cycle, then IDLE.
- start is ignored outside IDLE.
- With win_ready held high, each window costs 11 cycles.
- Backpressure of any length only stretches OUT. The SRAM is idle (sram_en=0) throughout OUT, DONE and IDLE.

Optional Feature:
- Macro: WIN_REPLICATE_EN.
- Defined: out-of-range tap coordinates are clamped to [0, IMG_W-1] and [0, IMG_H-1]. Every tap is read from the SRAM (sram_en=1 in all 9 issue cycles). Border pixels are therefore replicated.
- Undefined: zero padding as described in Behaviour.
- FETCH length (10 cycles) is identical in both builds.

Test Plan (IMG_W=4, IMG_H=4, ADDR_W=4; SRAM model preloaded with pixel(x,y) = 4y+x):
- Reset mid-FETCH of window (1,0) -> next cycle busy=0, sram_en=0, win_valid=0; no done pulse. A following start restarts the scan at (0,0).
- start, win_ready=1 -> first window (0,0) has taps k0..k8 = 0,0,0,0,0,1,0,4,5. Exactly 4 cycles with sram_en=1 in that FETCH.
- Interior window (1,1) -> taps 0,1,2,4,5,6,8,9,10; 9 SRAM reads. Corner window (3,3) -> taps 10,11,0,14,15,0,0,0,0.
- win_ready held low 20 cycles at window (2,1) -> win_valid stays 1, win_data stays constant, sram_en stays 0. Release -> scan resumes at (3,1).
- Full frame with win_ready=1 -> 16 handshakes in raster order, done pulses once, 176 cycles from the cycle after start to the last handshake. start pulsed mid-frame has no effect.
- WIN_REPLICATE_EN defined -> window (0,0) taps 0,0,1,0,0,1,4,4,5; window (3,3) taps 10,11,11,14,15,15,14,15,15; 9 reads per window.
